// File: rtl/count_uart_tx.sv
// count_uart_tx: buffers counter values offered on a valid/ready port in a small FIFO and
// sends each one as a UART frame on tx (start bit, 8 data bits LSB first, stop bit).
// Build option: define UART_PARITY_EN to insert an even-parity bit between data and stop.
// Reset is asynchronous and active-high on rst_n (the existing codebase convention).
module count_uart_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    count_in,
  input  logic                          count_vld,
  output logic                          count_rdy,
  input  logic                          clr_ovf,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BaudLast = 16'(CLK_DIV - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  // FIFO storage and wrap-bit pointers
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        full, empty, push, pop, drop;

  // Serializer state
  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;
  logic        baud_end;
`ifdef UART_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // Ready is held low while reset is asserted; otherwise it tracks full only, so a pop in
  // the same cycle never opens a slot for a push.
  assign count_rdy = ~rst_n & ~full;
  assign push      = count_vld & count_rdy;
  assign drop      = count_vld & ~count_rdy;

  assign fifo_level = wptr_q - rptr_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;

  // FIFO pointer and sticky overflow next-state
  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, push};
    rptr_d = rptr_q + {{AW{1'b0}}, pop};
    ovf_d  = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // Frame sequencing: pop in IDLE, then start, 8 data bits, optional parity, stop
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    baud_end = (baud_q == BaudLast);
`ifdef UART_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q[AW-1:0]];
          baud_d  = '0;
          bit_d   = '0;
          state_d = StStart;
`ifdef UART_PARITY_EN
          parity_d = ^mem_q[rptr_q[AW-1:0]];
`endif
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = StStop;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`endif
      StStop: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = StIdle;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // tx and busy are decoded from next state so both leave the flops glitch-free
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != StIdle);
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_PARITY_EN
      StParity: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // Control state; reset aborts any frame and flushes the FIFO
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef UART_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
`ifdef UART_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // FIFO storage write; contents need no reset since pointers gate every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= count_in;
    end
  end

endmodule

// File: tb/tb_count_uart_tx.sv
// Scoreboard bench for count_uart_tx: stimulus queues expected bytes, a UART receiver
// process decodes tx frames and compares them against the queue.
module tb_count_uart_tx;

  localparam int unsigned ClkDiv = 4;
  localparam int unsigned Depth  = 4;
`ifdef UART_PARITY_EN
  localparam int unsigned BitsPerFrame = 11;
`else
  localparam int unsigned BitsPerFrame = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] count_in;
  logic       count_vld;
  logic       count_rdy;
  logic       clr_ovf;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_level;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sb[$];

  logic [7:0] mon_d;
  logic [7:0] mon_exp;
  logic       mon_ok;
  logic       mon_abort;
  logic       mon_par;

  count_uart_tx #(
    .CLK_DIV   (ClkDiv),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .count_in  (count_in),
    .count_vld (count_vld),
    .count_rdy (count_rdy),
    .clr_ovf   (clr_ovf),
    .tx        (tx),
    .busy      (busy),
    .fifo_level(fifo_level),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Receiver: samples at negedge, one sample per clock, checks every sample of every bit
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n && tx === 1'b0) begin
        mon_ok    = 1'b1;
        mon_abort = 1'b0;
        mon_d     = 8'h00;
        mon_par   = 1'b0;
        for (int i = 1; i < ClkDiv; i++) begin
          @(negedge clk);
          if (rst_n) mon_abort = 1'b1;
          if (tx !== 1'b0) mon_ok = 1'b0;
        end
        for (int b = 0; b < 8; b++) begin
          for (int i = 0; i < ClkDiv; i++) begin
            @(negedge clk);
            if (rst_n) mon_abort = 1'b1;
            if (i == 0) mon_d[b] = tx;
            else if (tx !== mon_d[b]) mon_ok = 1'b0;
          end
        end
`ifdef UART_PARITY_EN
        for (int i = 0; i < ClkDiv; i++) begin
          @(negedge clk);
          if (rst_n) mon_abort = 1'b1;
          if (i == 0) mon_par = tx;
          else if (tx !== mon_par) mon_ok = 1'b0;
        end
`endif
        for (int i = 0; i < ClkDiv; i++) begin
          @(negedge clk);
          if (rst_n) mon_abort = 1'b1;
          if (tx !== 1'b1) mon_ok = 1'b0;
        end
        if (!mon_abort) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_frame: got data 0x%0h expected no frame", mon_d);
          end else begin
            mon_exp = sb.pop_front();
            check("frame_data", mon_d, mon_exp);
            check("frame_shape", mon_ok, 1'b1);
`ifdef UART_PARITY_EN
            check("frame_parity", mon_par, ^mon_exp);
`endif
          end
        end
      end
    end
  end

  // Watches busy/fifo_level until the block drains; gaps are idle samples with work pending
  task automatic measure(input int max_cyc, output int busy_n, output int gap_n,
                         output int gap_bad, output int peak, output logic first_busy,
                         output logic timed_out);
    bit started = 0;
    busy_n = 0; gap_n = 0; gap_bad = 0; peak = 0; first_busy = 1'b0; timed_out = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (c == 0) first_busy = busy;
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (busy) begin
        started = 1;
        busy_n++;
      end else if (started) begin
        if (fifo_level == 3'd0) begin
          timed_out = 1'b0;
          return;
        end
        gap_n++;
        if (tx !== 1'b1) gap_bad++;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int   busy_n, gap_n, gap_bad, peak, low_n;
  logic first_busy, timed_out;

  initial begin
    rst_n     = 1'b1;
    count_in  = 8'h00;
    count_vld = 1'b0;
    clr_ovf   = 1'b0;
    #1;
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_rdy", count_rdy, 1'b0);
    check("reset_level", fifo_level, 3'd0);
    check("reset_ovf", overflow, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rdy_after_release", count_rdy, 1'b1);

    // 1) single frame 0xA5, latency and length
    @(negedge clk);
    count_in  = 8'hA5;
    count_vld = 1'b1;
    sb.push_back(8'hA5);
    @(negedge clk);
    count_vld = 1'b0;
    count_in  = 8'h3C;
    check("t1_idle_before_pop_busy", busy, 1'b0);
    check("t1_idle_before_pop_tx", tx, 1'b1);
    check("t1_level_after_push", fifo_level, 3'd1);
    measure(200, busy_n, gap_n, gap_bad, peak, first_busy, timed_out);
    check("t1_busy_next_cycle", first_busy, 1'b1);
    check("t1_busy_cycles", busy_n, BitsPerFrame * ClkDiv);
    check("t1_timeout", timed_out, 1'b0);

    // 2) three back-to-back words
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          count_in  = 8'(i + 1);
          count_vld = 1'b1;
          sb.push_back(8'(i + 1));
        end
        @(negedge clk);
        count_vld = 1'b0;
        count_in  = 8'hFF;
      end
      measure(600, busy_n, gap_n, gap_bad, peak, first_busy, timed_out);
    join
    check("t2_busy_cycles", busy_n, 3 * BitsPerFrame * ClkDiv);
    check("t2_gap_cycles", gap_n, 2);
    check("t2_gap_tx_high", gap_bad, 0);
    check("t2_level_peak", peak, 2);
    check("t2_timeout", timed_out, 1'b0);

    // 3) overflow by holding valid for 8 cycles; 6) clear collides with drop
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 5) begin
        check("t3_level_full", fifo_level, 3'd4);
        check("t3_rdy_full", count_rdy, 1'b0);
        check("t3_ovf_before_drop", overflow, 1'b0);
      end
      if (i == 6) check("t3_ovf_set", overflow, 1'b1);
      count_in  = 8'(8'h10 + i);
      count_vld = 1'b1;
      if (i < 5) sb.push_back(8'(8'h10 + i));
    end
    @(negedge clk);
    count_in = 8'h18;
    clr_ovf  = 1'b1;
    @(negedge clk);
    count_vld = 1'b0;
    check("t6_set_wins", overflow, 1'b1);
    @(negedge clk);
    clr_ovf = 1'b0;
    check("t3_ovf_cleared", overflow, 1'b0);
    measure(800, busy_n, gap_n, gap_bad, peak, first_busy, timed_out);
    check("t3_gap_cycles", gap_n, 4);
    check("t3_timeout", timed_out, 1'b0);

    // 4) reset mid-DATA with two words queued
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      count_in  = 8'h00;
      count_vld = 1'b1;
      sb.push_back(8'h00);
    end
    @(negedge clk);
    count_vld = 1'b0;
    repeat (7) @(negedge clk);
    check("t4_busy_before_reset", busy, 1'b1);
    check("t4_tx_low_before_reset", tx, 1'b0);
    check("t4_level_before_reset", fifo_level, 3'd2);
    rst_n = 1'b1;
    sb.delete();
    #1;
    check("t4_reset_tx", tx, 1'b1);
    check("t4_reset_busy", busy, 1'b0);
    check("t4_reset_level", fifo_level, 3'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    low_n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) low_n++;
    end
    check("t4_quiet_after_reset", low_n, 0);
    check("t4_rdy_after_reset", count_rdy, 1'b1);

`ifdef UART_PARITY_EN
    // 5) parity frames
    @(negedge clk);
    count_in  = 8'h07;
    count_vld = 1'b1;
    sb.push_back(8'h07);
    @(negedge clk);
    count_vld = 1'b0;
    measure(200, busy_n, gap_n, gap_bad, peak, first_busy, timed_out);
    check("t5_frame_len", busy_n, 11 * ClkDiv);
    @(negedge clk);
    count_in  = 8'h03;
    count_vld = 1'b1;
    sb.push_back(8'h03);
    @(negedge clk);
    count_vld = 1'b0;
    measure(200, busy_n, gap_n, gap_bad, peak, first_busy, timed_out);
    check("t5_frame_len2", busy_n, 11 * ClkDiv);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
